itf_isa_packer: RTL and testbench

ITF_ISA_PACKER -- requirements
Module: itf_isa_packer

---
 rtl/itf_pkg.sv | 15 +
 rtl/isa_fifo.sv | 53 +++++
 rtl/itf_isa_packer.sv | 131 +++++++++++++
 tb/tb_itf_isa_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/itf_pkg.sv
// Shared definitions for the ISA interface packer: parameter defaults and FSM states.
package itf_pkg;

  localparam int unsigned PAD_WIDTH_DEF  = 32;
  localparam int unsigned PORT_WIDTH_DEF = 96;
  localparam int unsigned BEATS_DEF      = PORT_WIDTH_DEF / PAD_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/isa_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled ISA words.
module isa_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/itf_isa_packer.sv
// Packs PAD_WIDTH off-chip beats LSB-first into PORT_WIDTH ISA words and streams them to the CCU.
// Optional checksum output is enabled by defining ITF_ISA_CHKSUM_EN.
module itf_isa_packer
  import itf_pkg::*;
#(
  parameter int unsigned PAD_WIDTH  = PAD_WIDTH_DEF,
  parameter int unsigned PORT_WIDTH = PORT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  TOPITF_Start,
  input  logic [NUM_WIDTH-1:0]  TOPITF_NumWord,
  input  logic [PAD_WIDTH-1:0]  PADITF_Dat,
  input  logic                  PADITF_DatVld,
  output logic                  ITFPAD_DatRdy,
  output logic [PORT_WIDTH-1:0] ITFCCU_Dat,
  output logic                  ITFCCU_DatVld,
  input  logic                  CCUITF_DatRdy,
  output logic                  ITFTOP_Busy,
  output logic                  ITFTOP_Fnh
`ifdef ITF_ISA_CHKSUM_EN
  ,
  output logic [PORT_WIDTH-1:0] ITFTOP_ChkSum
`endif
);

  localparam int unsigned BEATS = PORT_WIDTH / PAD_WIDTH;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  state_e                state;
  state_e                state_nxt;
  logic [BCW-1:0]        beat_cnt;
  logic [NUM_WIDTH-1:0]  word_cnt;
  logic [NUM_WIDTH-1:0]  num_word;
  logic [PORT_WIDTH-1:0] pack_reg;
  logic [PORT_WIDTH-1:0] push_word;
  logic                  last_beat;
  logic                  beat_acc;
  logic                  push;
  logic                  last_push;
  logic                  pop;
  logic                  start_acc;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign start_acc     = (state == IDLE) && TOPITF_Start;
  assign last_beat     = (beat_cnt == BCW'(BEATS - 1));
  assign ITFPAD_DatRdy = (state == PACK) && !(last_beat && fifo_full);
  assign beat_acc      = PADITF_DatVld && ITFPAD_DatRdy;
  assign push          = beat_acc && last_beat;
  assign last_push     = push && ((word_cnt + NUM_WIDTH'(1)) == num_word);
  assign pop           = CCUITF_DatRdy && !fifo_empty;
  assign ITFCCU_DatVld = !fifo_empty;
  assign ITFTOP_Busy   = (state != IDLE);
  assign ITFTOP_Fnh    = (state == DONE);

  // The final beat bypasses pack_reg so the word is pushed in its acceptance cycle.
  always_comb begin
    push_word = pack_reg;
    push_word[beat_cnt*PAD_WIDTH +: PAD_WIDTH] = PADITF_Dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (TOPITF_Start) state_nxt = (TOPITF_NumWord == '0) ? DONE : PACK;
      PACK:    if (last_push) state_nxt = DRAIN;
      DRAIN:   if (pop && (fifo_count == CW'(1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      word_cnt <= '0;
      num_word <= '0;
      pack_reg <= '0;
    end else begin
      if (start_acc) begin
        num_word <= TOPITF_NumWord;
        word_cnt <= '0;
        beat_cnt <= '0;
      end
      if (beat_acc) begin
        pack_reg[beat_cnt*PAD_WIDTH +: PAD_WIDTH] <= PADITF_Dat;
        beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
      end
      if (push) word_cnt <= word_cnt + NUM_WIDTH'(1);
    end
  end

  isa_fifo #(
    .WIDTH (PORT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (ITFCCU_Dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ITF_ISA_CHKSUM_EN
  logic [PORT_WIDTH-1:0] chk_reg;

  // Running XOR of every pushed word since the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         chk_reg <= '0;
    else if (start_acc) chk_reg <= '0;
    else if (push)      chk_reg <= chk_reg ^ push_word;
  end

  assign ITFTOP_ChkSum = chk_reg;
`endif

endmodule

// File: tb/tb_itf_isa_packer.sv
// Self-checking bench for itf_isa_packer against a queue-based transfer model.
module tb_itf_isa_packer;

  localparam int unsigned PAD   = 32;
  localparam int unsigned PORT  = 96;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NW    = 16;
  localparam int unsigned BEATS = PORT / PAD;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [NW-1:0]   num_word;
  logic [PAD-1:0]  pad_dat;
  logic            pad_vld;
  logic            pad_rdy;
  logic [PORT-1:0] ccu_dat;
  logic            ccu_vld;
  logic            ccu_rdy;
  logic            busy;
  logic            fnh;
`ifdef ITF_ISA_CHKSUM_EN
  logic [PORT-1:0] chksum;
`endif

  always #5 clk = ~clk;

  itf_isa_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .TOPITF_Start   (start),
    .TOPITF_NumWord (num_word),
    .PADITF_Dat     (pad_dat),
    .PADITF_DatVld  (pad_vld),
    .ITFPAD_DatRdy  (pad_rdy),
    .ITFCCU_Dat     (ccu_dat),
    .ITFCCU_DatVld  (ccu_vld),
    .CCUITF_DatRdy  (ccu_rdy),
    .ITFTOP_Busy    (busy),
    .ITFTOP_Fnh     (fnh)
`ifdef ITF_ISA_CHKSUM_EN
    ,
    .ITFTOP_ChkSum  (chksum)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Transfer model: beats collect into words, words queue up for the CCU.
  bit              m_active;
  bit              m_fnh;
  int              m_num;
  int              m_pushed;
  int              m_beats_total;
  logic [PAD-1:0]  m_part[$];
  logic [PORT-1:0] m_q[$];
  logic [PORT-1:0] m_log[$];
  logic [PORT-1:0] m_xor;
  bit              prev_stall;
  logic [PORT-1:0] prev_dat;

  task automatic chk(input string tag, input logic [PORT-1:0] obs, input logic [PORT-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_fnh = 1'b0;
    m_num = 0;
    m_pushed = 0;
    m_part.delete();
    m_q.delete();
    m_xor = '0;
    prev_stall = 1'b0;
  endtask

  task automatic tick(input logic st, input logic [NW-1:0] num, input logic vld,
                      input logic [PAD-1:0] dat, input logic rdy);
    logic            exp_vld;
    logic            exp_prdy;
    logic            acc;
    logic            pp;
    logic [PORT-1:0] w;
    start = st; num_word = num; pad_vld = vld; pad_dat = dat; ccu_rdy = rdy;
    #1;
    exp_vld  = (m_q.size() != 0);
    exp_prdy = m_active && !m_fnh && (m_pushed < m_num) &&
               !((m_part.size() == BEATS - 1) && (m_q.size() == DEPTH));
    chk("busy", PORT'(busy), PORT'(m_active));
    chk("fnh", PORT'(fnh), PORT'(m_fnh));
    chk("ccu_vld", PORT'(ccu_vld), PORT'(exp_vld));
    chk("pad_rdy", PORT'(pad_rdy), PORT'(exp_prdy));
    if (exp_vld) chk("ccu_dat", ccu_dat, m_q[0]);
    if (prev_stall) chk("dat_hold", ccu_dat, prev_dat);
`ifdef ITF_ISA_CHKSUM_EN
    if (m_fnh) chk("chksum", chksum, m_xor);
`endif
    acc = vld && exp_prdy;
    pp  = exp_vld && rdy;
    prev_stall = exp_vld && !rdy;
    prev_dat   = ccu_dat;
    if (pp) begin
      w = m_q.pop_front();
      m_log.push_back(w);
    end
    if (acc) begin
      m_part.push_back(dat);
      m_beats_total++;
      if (m_part.size() == BEATS) begin
        for (int i = 0; i < BEATS; i++) w[i*PAD +: PAD] = m_part[i];
        m_q.push_back(w);
        m_xor ^= w;
        m_pushed++;
        m_part.delete();
      end
    end
    if (m_fnh) begin
      m_fnh = 1'b0;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_num = int'(num);
        m_pushed = 0;
        m_xor = '0;
        m_part.delete();
        if (num == '0) m_fnh = 1'b1;
      end
    end else if (pp && (m_pushed == m_num) && (m_q.size() == 0)) begin
      m_fnh = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; stray starts while busy must be ignored.
  task automatic run_xfer(input int num, input int vld_pct, input int rdy_pct,
                          input int rdy_hold, input bit seq);
    int             cyc;
    logic           v;
    logic           r;
    logic           s;
    logic [PAD-1:0] d;
    m_beats_total = 0;
    m_log.delete();
    tick(1'b1, NW'(num), 1'b0, '0, 1'b0);
    cyc = 0;
    while (m_active && cyc < 5000) begin
      v = ($urandom_range(99) < vld_pct);
      r = (cyc >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      s = ($urandom_range(7) == 0);
      d = seq ? PAD'(m_beats_total + 1) : PAD'($urandom());
      tick(s, NW'($urandom_range(9)), v, d, r);
      cyc++;
    end
    chk("xfer_complete", PORT'(busy), PORT'(0));
    chk("words_delivered", PORT'(m_log.size()), PORT'(num));
  endtask

  initial begin
    int cyc;
    model_reset();
    rst_n = 1'b0;
    start = 1'b0; num_word = '0; pad_vld = 1'b0; pad_dat = '0; ccu_rdy = 1'b0;
    #2;
    chk("rst_busy", PORT'(busy), PORT'(0));
    chk("rst_fnh", PORT'(fnh), PORT'(0));
    chk("rst_ccu_vld", PORT'(ccu_vld), PORT'(0));
    chk("rst_pad_rdy", PORT'(pad_rdy), PORT'(0));
    chk("rst_ccu_dat", ccu_dat, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two words from beats 1..6 with the CCU always ready.
    run_xfer(2, 100, 100, 0, 1'b1);
    chk("w0_value", m_log[0], 96'h000000030000000200000001);
    chk("w1_value", m_log[1], 96'h000000060000000500000004);

    // Five words with the CCU stalled until the FIFO fills and the pad side backs up.
    run_xfer(5, 100, 100, 30, 1'b1);
    chk("w4_value", m_log[4], 96'h0000000f0000000e0000000d);

    // Zero-word start goes straight to the done pulse.
    run_xfer(0, 100, 100, 0, 1'b1);

    // Reset after four beats of a three-word transfer.
    m_beats_total = 0;
    tick(1'b1, NW'(3), 1'b0, '0, 1'b0);
    cyc = 0;
    while (m_beats_total < 4 && cyc < 20) begin
      tick(1'b0, '0, 1'b1, PAD'(m_beats_total + 1), 1'b0);
      cyc++;
    end
    chk("four_beats_in", PORT'(m_beats_total), PORT'(4));
    pad_vld = 1'b0; start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", PORT'(busy), PORT'(0));
    chk("mid_rst_fnh", PORT'(fnh), PORT'(0));
    chk("mid_rst_ccu_vld", PORT'(ccu_vld), PORT'(0));
    chk("mid_rst_pad_rdy", PORT'(pad_rdy), PORT'(0));
    chk("mid_rst_ccu_dat", ccu_dat, '0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, '1, 1'b1);
    run_xfer(3, 80, 80, 0, 1'b1);

    // Long random transfers with stalls on both sides.
    run_xfer(64, 60, 50, 0, 1'b0);
    run_xfer(64, 85, 25, 0, 1'b0);
    run_xfer(7, 30, 90, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
